// File: rtl/persiana_motor_drv.sv
// Motor power-stage driver behind the blind FSM.
// Adds dead time, limit stops, travel watchdog, sensor fault and a soft-start PWM ramp.
module persiana_motor_drv #(
    parameter int DEAD_TICKS    = 4,
    parameter int TIMEOUT_TICKS = 20,
    parameter int RAMP_START    = 64,
    parameter int RAMP_STEP     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       subir,
    input  logic       bajar,
    input  logic       lim_sup,
    input  logic       lim_inf,
    input  logic       fault_clr,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       motor_pwm,
    output logic       moving,
    output logic       fault,
    output logic [2:0] state
);
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DW-1:0] DEAD_MAX   = DW'(DEAD_TICKS);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_TICKS);
    localparam logic [7:0]    DUTY_START = 8'(RAMP_START);
    localparam logic [8:0]    DUTY_STEP  = 9'(RAMP_STEP);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD   = 3'd1,
        RUN_UP = 3'd2,
        RUN_DN = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t        st, st_nxt;
    logic          target_up, target_up_nxt;
    logic [DW-1:0] dead_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    duty;
    logic [7:0]    pwm_cnt;
    logic          up_req, dn_req, both_lim, run_nxt;
    logic [8:0]    duty_sum;

    // Simultaneous subir and bajar is treated as no request at all.
    assign up_req   = subir & ~bajar;
    assign dn_req   = bajar & ~subir;
    assign both_lim = lim_sup & lim_inf;
    assign run_nxt  = (st_nxt == RUN_UP) || (st_nxt == RUN_DN);
    assign duty_sum = {1'b0, duty} + DUTY_STEP;

    always_comb begin
        st_nxt        = st;
        target_up_nxt = target_up;
        if (both_lim && st != FAULT) begin
            st_nxt = FAULT;
        end else begin
            case (st)
                IDLE: begin
                    if (up_req && !lim_sup) begin
                        st_nxt        = DEAD;
                        target_up_nxt = 1'b1;
                    end else if (dn_req && !lim_inf) begin
                        st_nxt        = DEAD;
                        target_up_nxt = 1'b0;
                    end
                end
                DEAD: begin
                    if (target_up ? !up_req : !dn_req)
                        st_nxt = IDLE;
                    else if (dead_cnt >= DEAD_MAX)
                        st_nxt = target_up ? (lim_sup ? IDLE : RUN_UP)
                                           : (lim_inf ? IDLE : RUN_DN);
                end
                RUN_UP: begin
                    if (lim_sup || !up_req)  st_nxt = IDLE;
                    else if (to_cnt >= TO_MAX) st_nxt = FAULT;
                end
                RUN_DN: begin
                    if (lim_inf || !dn_req)  st_nxt = IDLE;
                    else if (to_cnt >= TO_MAX) st_nxt = FAULT;
                end
                FAULT: begin
                    if (fault_clr && !subir && !bajar && !both_lim) st_nxt = IDLE;
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    // Counters restart whenever their state is (re)entered and saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            target_up <= 1'b0;
            dead_cnt  <= '0;
            to_cnt    <= '0;
            duty      <= 8'd0;
            pwm_cnt   <= 8'd0;
        end else begin
            st        <= st_nxt;
            target_up <= target_up_nxt;
            pwm_cnt   <= pwm_cnt + 8'd1;
            if (st_nxt == DEAD && st == DEAD) begin
                if (tick && dead_cnt < DEAD_MAX) dead_cnt <= dead_cnt + 1'b1;
            end else begin
                dead_cnt <= '0;
            end
            if (run_nxt && st_nxt == st) begin
                if (tick) begin
                    if (to_cnt < TO_MAX) to_cnt <= to_cnt + 1'b1;
                    duty <= (duty_sum > 9'd255) ? 8'hFF : duty_sum[7:0];
                end
            end else if (run_nxt) begin
                duty   <= DUTY_START;
                to_cnt <= '0;
            end else begin
                duty   <= 8'd0;
                to_cnt <= '0;
            end
        end
    end

    assign motor_en  = (st == RUN_UP) || (st == RUN_DN);
    assign motor_dir = (st == RUN_UP);
    assign moving    = motor_en;
    assign fault     = (st == FAULT);
    assign state     = st;
    assign motor_pwm = motor_en & ((duty == 8'hFF) | (pwm_cnt < duty));

endmodule

// File: tb/tb_persiana_motor_drv.sv
// Self-checking bench for persiana_motor_drv: directed stimulus plus a
// tick-counting reference model compared on every falling clock edge.
module tb_persiana_motor_drv;
    localparam int DEAD_TICKS    = 4;
    localparam int TIMEOUT_TICKS = 20;
    localparam int RAMP_START    = 64;
    localparam int RAMP_STEP     = 32;

    logic       clk = 1'b0;
    logic       rst_n, tick, subir, bajar, lim_sup, lim_inf, fault_clr;
    logic       motor_en, motor_dir, motor_pwm, moving, fault;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;
    int dead_ticks = 0;
    int dn_ticks = 0;
    int phase = 0;

    int m_mode, m_ticks, m_cyc, m_nm;
    bit m_up;

    persiana_motor_drv #(
        .DEAD_TICKS(DEAD_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .RAMP_START(RAMP_START), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .subir(subir), .bajar(bajar),
        .lim_sup(lim_sup), .lim_inf(lim_inf), .fault_clr(fault_clr),
        .motor_en(motor_en), .motor_dir(motor_dir), .motor_pwm(motor_pwm),
        .moving(moving), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Time base: one tick every 8 clocks, changed just after the rising edge.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 8;
            tick  = (phase == 0);
        end
    end

    // Model: mode 0 idle, 1 dead, 2 up, 3 down, 4 fault; ticks counts ticks spent in the current mode.
    function automatic int model_next(int mode, int ticks, bit tgt_up, logic s, logic b,
                                      logic ls, logic li, logic clr);
        bit upr = s && !b;
        bit dnr = b && !s;
        bit want, lim;
        if (ls && li && mode != 4) return 4;
        case (mode)
            0: return ((upr && !ls) || (dnr && !li)) ? 1 : 0;
            1: begin
                want = tgt_up ? upr : dnr;
                lim  = tgt_up ? ls : li;
                if (!want) return 0;
                if (ticks < DEAD_TICKS) return 1;
                return lim ? 0 : (tgt_up ? 2 : 3);
            end
            2, 3: begin
                want = (mode == 2) ? upr : dnr;
                lim  = (mode == 2) ? ls : li;
                if (lim || !want) return 0;
                if (ticks >= TIMEOUT_TICKS) return 4;
                return mode;
            end
            4: return (clr && !s && !b && !(ls && li)) ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_outputs(int mode, int ticks, int cyc);
        int d;
        bit en, pwm;
        en  = (mode == 2) || (mode == 3);
        d   = RAMP_START + RAMP_STEP * ticks;
        if (d > 255) d = 255;
        pwm = en && (d == 255 || (cyc % 256) < d);
        return {3'(mode), en, (mode == 2), pwm, en, (mode == 4)};
    endfunction

    assign m_nm = model_next(m_mode, m_ticks, m_up, subir, bajar, lim_sup, lim_inf, fault_clr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_ticks <= 0;
            m_up    <= 1'b0;
            m_cyc   <= 0;
        end else begin
            m_cyc  <= (m_cyc + 1) % 256;
            m_mode <= m_nm;
            if (m_mode == 0 && m_nm == 1) m_up <= subir && !bajar && !lim_sup;
            if (m_nm != m_mode) m_ticks <= 0;
            else if (tick && m_ticks < 1000) m_ticks <= m_ticks + 1;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge, compare against the model and update tick statistics.
    task automatic cycle();
        logic [7:0] act, exp_v;
        @(negedge clk);
        act   = {state, motor_en, motor_dir, motor_pwm, moving, fault};
        exp_v = model_outputs(m_mode, m_ticks, m_cyc);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL model_compare t=%0t: dut {state,en,dir,pwm,moving,fault}=%b expected %b",
                     $time, act, exp_v);
        end
        if (state == 3'd0) begin
            dead_ticks = 0;
            dn_ticks   = 0;
        end else begin
            if (state == 3'd1 && tick) dead_ticks++;
            if (state == 3'd3 && tick) dn_ticks++;
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state !== target && n < budget) begin
            cycle();
            n++;
        end
        check_output(name, int'(state), int'(target));
    endtask

    task automatic apply_stimulus(input logic s, input logic b, input logic ls, input logic li,
                                  input logic clr);
        subir = s; bajar = b; lim_sup = ls; lim_inf = li; fault_clr = clr;
    endtask

    initial begin
        int n, gap_en, pwm_hi;
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0);
        repeat (3) cycle();
        check_output("reset_state", int'(state), 0);
        check_output("reset_motor_en", int'(motor_en), 0);
        #2 rst_n = 1'b1;
        cycle();
        check_output("post_reset_state", int'(state), 0);
        check_output("post_reset_fault", int'(fault), 0);

        // Raise with soft-start ramp.
        apply_stimulus(1, 0, 0, 0, 0);
        cycle();
        check_output("enter_dead", int'(state), 1);
        wait_state(3'd2, 100, "reach_run_up");
        check_output("dead_ticks_up", dead_ticks, DEAD_TICKS);
        check_output("run_up_dir", int'(motor_dir), 1);
        check_output("run_up_en", int'(motor_en), 1);
        repeat (64) cycle();
        pwm_hi = 0;
        repeat (16) begin
            cycle();
            if (motor_pwm) pwm_hi++;
        end
        check_output("pwm_full_duty", pwm_hi, 16);

        // Upper limit stops immediately; request toward that limit is ignored.
        lim_sup = 1'b1;
        cycle();
        check_output("lim_sup_stop", int'(state), 0);
        repeat (20) cycle();
        check_output("ignore_at_limit", int'(state), 0);
        apply_stimulus(0, 0, 0, 0, 0);
        cycle();

        // Request dropped during dead time aborts the start.
        subir = 1'b1;
        cycle();
        check_output("dead_again", int'(state), 1);
        repeat (10) cycle();
        subir = 1'b0;
        cycle();
        check_output("dead_abort", int'(state), 0);

        // Asynchronous reset in the middle of a run.
        subir = 1'b1;
        wait_state(3'd2, 100, "run_before_reset");
        repeat (60) cycle();
        check_output("pwm_before_reset", int'(motor_pwm), 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_motor_en", int'(motor_en), 0);
        check_output("async_motor_pwm", int'(motor_pwm), 0);
        check_output("async_moving", int'(moving), 0);
        subir = 1'b0;
        cycle();
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        check_output("after_async_reset", int'(state), 0);

        // Reversal from down to up passes through IDLE and a full dead time.
        bajar = 1'b1;
        wait_state(3'd3, 100, "reach_run_dn");
        repeat (20) cycle();
        apply_stimulus(1, 0, 0, 0, 0);
        cycle();
        check_output("reversal_stop", int'(state), 0);
        n = 0;
        gap_en = 0;
        while (state != 3'd2 && n < 200) begin
            cycle();
            if (state != 3'd2 && motor_en) gap_en++;
            n++;
        end
        check_output("reversal_run_up", int'(state), 2);
        check_output("reversal_gap_en", gap_en, 0);
        check_output("reversal_dead_ticks", dead_ticks, DEAD_TICKS);

        // Travel watchdog.
        apply_stimulus(0, 1, 0, 0, 0);
        wait_state(3'd3, 100, "timeout_run_dn");
        wait_state(3'd4, 250, "timeout_fault");
        check_output("timeout_run_ticks", dn_ticks, TIMEOUT_TICKS);
        check_output("timeout_fault_flag", int'(fault), 1);
        check_output("timeout_motor_off", int'(motor_en), 0);
        fault_clr = 1'b1;
        repeat (10) cycle();
        check_output("clr_with_request", int'(state), 4);
        bajar = 1'b0;
        cycle();
        check_output("clr_to_idle", int'(state), 0);
        fault_clr = 1'b0;
        cycle();

        // Both limits set: sensor fault from IDLE and from RUN_UP.
        apply_stimulus(0, 0, 1, 1, 0);
        cycle();
        check_output("both_lim_idle", int'(state), 4);
        fault_clr = 1'b1;
        repeat (5) cycle();
        check_output("clr_with_both_lim", int'(state), 4);
        apply_stimulus(0, 0, 0, 0, 1);
        cycle();
        check_output("clr_sensor_fault", int'(state), 0);
        apply_stimulus(1, 0, 0, 0, 0);
        wait_state(3'd2, 100, "run_before_both");
        apply_stimulus(1, 0, 1, 1, 0);
        cycle();
        check_output("both_lim_run", int'(state), 4);
        check_output("both_lim_run_en", int'(motor_en), 0);
        apply_stimulus(0, 0, 0, 0, 1);
        cycle();
        check_output("final_clear", int'(state), 0);
        fault_clr = 1'b0;
        repeat (5) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
